// File: rtl/quad_sample_collector_if.sv
// Sample stream into the quad collector: valid/ready handshake with the
// sample word, plus the downstream stall and the group-discard controls.
interface quad_sample_collector_if #(
  parameter int DATA_W = 13
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              hold;
  logic              flush;

  // Sample source: drives the beat and the stall/flush controls, sees ready.
  modport master (
    output s_valid,
    output s_data,
    output hold,
    output flush,
    input  s_ready
  );

  // Collector side: consumes beats and reports whether it can take one.
  modport slave (
    input  s_valid,
    input  s_data,
    input  hold,
    input  flush,
    output s_ready
  );
endinterface

// File: rtl/quad_sample_collector.sv
// Packs a serial stream of samples into groups of four that feed the 4-input
// pipelined adder. It also produces a group strobe and a sum_valid pulse.
// The sum_valid pulse is delayed so that it lands in the cycle where the
// adder output holds that group's sum.
module quad_sample_collector #(
  parameter int DATA_W        = 13,
  parameter int ADDER_LATENCY = 2,
  parameter int CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  quad_sample_collector_if.slave s,
  output logic [DATA_W-1:0]     in1,
  output logic [DATA_W-1:0]     in2,
  output logic [DATA_W-1:0]     in3,
  output logic [DATA_W-1:0]     in4,
  output logic                  grp_strobe,
  output logic                  sum_valid,
  output logic [2:0]            fill_level,
  output logic [CNT_W-1:0]      grp_count
);

  // Number of samples collected so far in the current partial group.
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  state_t                   state;
  logic [DATA_W-1:0]        shadow0;
  logic [DATA_W-1:0]        shadow1;
  logic [DATA_W-1:0]        shadow2;
  logic [ADDER_LATENCY-1:0] strobe_pipe;
  logic                     accept;

  // Ready never looks at s_valid, which keeps the handshake free of
  // combinational loops. It is forced low while reset is asserted.
  assign s.s_ready = rst_n & ~s.hold & ~s.flush;
  assign accept    = s.s_valid & s.s_ready;

  // The state encoding is the sample count, so fill level comes straight from the state register.
  assign fill_level = {1'b0, state};

  // The last stage of the delay chain is the registered sum_valid.
  assign sum_valid = strobe_pipe[ADDER_LATENCY-1];

  // Collection FSM: fills the shadow registers, then on the fourth beat
  // loads all four adder operands at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shadow words are only three registers, not a RAM, so they
      // get a reset value along with everything else; a real memory array
      // would be left unreset.
      state      <= S0;
      shadow0    <= '0;
      shadow1    <= '0;
      shadow2    <= '0;
      in1        <= '0;
      in2        <= '0;
      in3        <= '0;
      in4        <= '0;
      grp_strobe <= 1'b0;
      grp_count  <= '0;
    end else begin
      // NOTE: all state uses non-blocking assignments. Every right-hand side
      // then sees the pre-edge value; for example, in4 takes s_data in the
      // same edge in which the state returns to S0.
      grp_strobe <= 1'b0;
      if (s.flush) begin
        state <= S0;
      end else if (accept) begin
        case (state)
          S0: begin
            shadow0 <= s.s_data;
            state   <= S1;
          end
          S1: begin
            shadow1 <= s.s_data;
            state   <= S2;
          end
          S2: begin
            shadow2 <= s.s_data;
            state   <= S3;
          end
          S3: begin
            in1        <= shadow0;
            in2        <= shadow1;
            in3        <= shadow2;
            in4        <= s.s_data;
            grp_strobe <= 1'b1;
            grp_count  <= grp_count + 1'b1;
            state      <= S0;
          end
          default: state <= S0;
        endcase
      end
    end
  end

  // Delay chain for grp_strobe. It matches the adder latency, keeps shifting
  // through hold and flush, and is cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_pipe <= '0;
    end else begin
      strobe_pipe[0] <= grp_strobe;
      for (int i = 1; i < ADDER_LATENCY; i++) begin
        strobe_pipe[i] <= strobe_pipe[i-1];
      end
    end
  end

endmodule

// File: tb/tb_quad_sample_collector.sv
// Testbench for quad_sample_collector. The bench keeps its own model of the
// collector: a queue of accepted samples, a history of group completions
// used for sum_valid timing, and a behavioural 2-stage adder so the sum can
// be checked in the sum_valid cycle.
module tb_quad_sample_collector;

  localparam int DATA_W = 13;
  localparam int LAT    = 2;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] in1, in2, in3, in4;
  logic              grp_strobe, sum_valid;
  logic [2:0]        fill_level;
  logic [CNT_W-1:0]  grp_count;

  quad_sample_collector_if #(.DATA_W(DATA_W)) bus ();

  quad_sample_collector #(
    .DATA_W(DATA_W), .ADDER_LATENCY(LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s(bus.slave),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .grp_strobe(grp_strobe), .sum_valid(sum_valid),
    .fill_level(fill_level), .grp_count(grp_count)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the downstream 4-input adder with 2-cycle latency.
  logic [14:0] a_stage, a_out;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_stage <= '0;
      a_out   <= '0;
    end else begin
      a_stage <= 15'(in1) + 15'(in2) + 15'(in3) + 15'(in4);
      a_out   <= a_stage;
    end
  end

  int compared = 0;
  int mismatched = 0;

  // Reference model state.
  int               part[$];
  int               e_in[4];
  logic             e_strobe;
  logic [CNT_W-1:0] e_cnt;
  bit               comp_q[$];
  int               sum_q[$];
  logic             e_sv;
  int               e_sum;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    part.delete();
    for (int i = 0; i < 4; i++) e_in[i] = 0;
    e_strobe = 1'b0;
    e_cnt    = '0;
    comp_q.delete();
    sum_q.delete();
    e_sv  = 1'b0;
    e_sum = 0;
  endtask

  // One rising edge of the model: flush empties the partial group, the
  // fourth accepted sample publishes the group, and sum_valid follows a
  // group completion by exactly LAT edges.
  task automatic model_edge(input logic acc, input int d, input logic f);
    bit done = 1'b0;
    int s    = 0;
    if (f) begin
      part.delete();
    end else if (acc) begin
      part.push_back(d);
      if (part.size() == 4) begin
        for (int i = 0; i < 4; i++) begin
          e_in[i] = part[i];
          s += part[i];
        end
        done  = 1'b1;
        e_cnt = e_cnt + 8'd1;
        part.delete();
      end
    end
    e_strobe = done;
    comp_q.push_front(done);
    sum_q.push_front(s);
    if (comp_q.size() > LAT) begin
      e_sv  = comp_q.pop_back();
      e_sum = sum_q.pop_back();
    end else begin
      e_sv = 1'b0;
    end
  endtask

  task automatic check_outputs();
    chk("in1", 32'(in1), 32'(e_in[0]));
    chk("in2", 32'(in2), 32'(e_in[1]));
    chk("in3", 32'(in3), 32'(e_in[2]));
    chk("in4", 32'(in4), 32'(e_in[3]));
    chk("grp_strobe", 32'(grp_strobe), 32'(e_strobe));
    chk("sum_valid", 32'(sum_valid), 32'(e_sv));
    chk("fill_level", 32'(fill_level), 32'(part.size()));
    chk("grp_count", 32'(grp_count), 32'(e_cnt));
    if (e_sv) chk("adder_out", 32'(a_out), 32'(e_sum));
  endtask

  // One clock cycle. Inputs are driven at the falling edge and s_ready is
  // checked combinationally. The model is then advanced at the rising edge,
  // and the registered outputs are checked 1 ns after that edge.
  task automatic step(input logic v, input int d, input logic h, input logic f);
    logic acc;
    @(negedge clk);
    bus.s_valid = v;
    bus.s_data  = DATA_W'(d);
    bus.hold    = h;
    bus.flush   = f;
    #1;
    chk("s_ready", 32'(bus.s_ready), 32'(rst_n & ~h & ~f));
    acc = v & rst_n & ~h & ~f;
    @(posedge clk);
    if (rst_n) model_edge(acc, d, f);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.hold    = 1'b0;
    bus.flush   = 1'b0;
    rst_n       = 1'b0;
    model_reset();

    // Reset state.
    #2;
    chk("reset_s_ready", 32'(bus.s_ready), 32'd0);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Single group 1,2,3,4 -> adder out 10.
    for (int i = 1; i <= 4; i++) step(1'b1, i, 1'b0, 1'b0);
    idle(4);

    // Max values -> adder out 32764.
    for (int i = 0; i < 4; i++) step(1'b1, 8191, 1'b0, 1'b0);
    idle(4);

    // Back-to-back groups 1..8 -> out 10 then 26.
    for (int i = 1; i <= 8; i++) step(1'b1, i, 1'b0, 1'b0);
    idle(4);

    // Hold after two beats while s_valid stays high.
    step(1'b1, 10, 1'b0, 1'b0);
    step(1'b1, 20, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 999, 1'b1, 1'b0);
    step(1'b1, 30, 1'b0, 1'b0);
    step(1'b1, 40, 1'b0, 1'b0);
    idle(4);

    // Flush a partial group, then collect a fresh one.
    step(1'b1, 9, 1'b0, 1'b0);
    step(1'b1, 9, 1'b0, 1'b0);
    step(1'b1, 9, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) step(1'b1, i, 1'b0, 1'b0);
    idle(3);

    // Flush and hold together: flush still empties the partial group.
    step(1'b1, 77, 1'b0, 1'b0);
    step(1'b1, 88, 1'b1, 1'b1);
    idle(2);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic v, h, f;
      v = ($urandom_range(0, 99) < 70);
      h = ($urandom_range(0, 99) < 15);
      f = ($urandom_range(0, 99) < 4);
      step(v, int'($urandom_range(0, 8191)), h, f);
    end
    idle(4);

    // Reset one cycle after grp_strobe: the pending sum_valid must never appear.
    for (int i = 5; i <= 8; i++) step(1'b1, i, 1'b0, 1'b0);
    idle(1);
    @(negedge clk);
    rst_n = 1'b0;
    bus.s_valid = 1'b0;
    model_reset();
    #1;
    chk("midrst_s_ready", 32'(bus.s_ready), 32'd0);
    chk("midrst_sum_valid", 32'(sum_valid), 32'd0);
    chk("midrst_grp_count", 32'(grp_count), 32'd0);
    check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/quad_sample_collector.md
Name: quad_sample_collector

Overview:
- Upstream feeder for the 4-input pipelined adder (13-bit in1..in4, 15-bit registered sum, 2-cycle latency).
- Accepts a serial stream of 13-bit samples over a valid/ready handshake and packs each group of four into parallel registers driving in1..in4.
- Generates a group strobe, plus a sum_valid pulse delayed to align with the cycle in which the adder's out holds that group's sum.

Parameters:
- DATA_W, 13, sample width; must match adder input width.
- ADDER_LATENCY, 2, clock edges from in1..in4 change to the adder's out update; sets the sum_valid delay.
- CNT_W, 8, width of the group counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- s_valid  input  1  upstream sample valid.
- s_ready  output  1  block can accept a sample this cycle.
- s_data  input  DATA_W  upstream sample.
- hold  input  1  downstream stall; forces s_ready low.
- flush  input  1  discard the partially collected group.
- in1  output  DATA_W  group sample 0 (first accepted); to adder in1.
- in2  output  DATA_W  group sample 1; to adder in2.
- in3  output  DATA_W  group sample 2; to adder in3.
- in4  output  DATA_W  group sample 3 (last accepted); to adder in4.
- grp_strobe  output  1  one-cycle pulse: in1..in4 hold a new group this cycle.
- sum_valid  output  1  one-cycle pulse: adder out holds this group's sum.
- fill_level  output  3  samples held in the current partial group, 0..3.
- grp_count  output  CNT_W  completed groups since reset; wraps.

Behaviour:
- Reset (async, rst_n low):
  - in1..in4, shadow regs, fill_level, grp_count, grp_strobe and sum_valid all go to 0.
  - The delay pipeline clears; state goes to S0.
  - s_ready goes low while rst_n is low.
- Handshake:
  - s_ready = rst_n & ~hold & ~flush, combinational, no dependency on s_valid.
  - A beat is accepted on a rising edge when s_valid & s_ready.
  - s_data is sampled only on accepted beats.
- FSM:
  - States are S0..S3, meaning 0..3 samples collected; fill_level equals the state index.
  - On an accepted beat in S0, S1 or S2: store s_data in shadow[state] and advance one state.
  - On an accepted beat in S3: load in1..in4 from shadow[0], shadow[1], shadow[2] and s_data at the same edge, then return to S0. Back-to-back groups need no idle cycle.
  - No accept means the state holds.
- Outputs:
  - in1..in4 change only at group completion; otherwise they hold. The adder sees stable operands between groups.
  - grp_strobe is registered and is high for exactly the cycle after the completing edge.
  - grp_count increments at the completing edge, modulo 2^CNT_W.
- sum_valid alignment:
  - grp_strobe is passed through an ADDER_LATENCY-deep register chain, so sum_valid rises ADDER_LATENCY cycles after grp_strobe.
  - With the default, sum_valid is high in the same cycle the adder's out first shows in1+in2+in3+in4.
  - Groups completing on consecutive edges produce consecutive sum_valid pulses.
- flush:
  - At the next edge, state goes to S0; shadow contents become don't-care.
  - in1..in4 and grp_count are unchanged.
  - Because s_ready is low during flush, no beat is accepted in the flush cycle.
  - In-flight strobe/sum_valid pulses are not cancelled.
- hold:
  - Blocks acceptance only; the state holds.
  - The delay pipeline keeps shifting.
- Simultaneous flush and hold: flush wins the state update.
- Reset mid-group or mid-pipeline drops all partial data and pending pulses.
- Arithmetic: none. Data passes through unmodified; no width change.

Test Plan:
- Single group:
  - Stimulus: reset, then beats 1, 2, 3, 4 on consecutive cycles.
  - Response: in1..in4 = 1, 2, 3, 4; grp_strobe one cycle after the 4th accept; sum_valid 2 cycles after grp_strobe; adder out = 10 in that cycle; grp_count = 1.
- Max values:
  - Stimulus: four beats of 8191.
  - Response: in1..in4 = 8191; adder out = 32764 when sum_valid = 1.
- Back-to-back groups:
  - Stimulus: 8 continuous beats, values 1..8.
  - Response: grp_strobe pulses 4 cycles apart; in1..in4 = 5, 6, 7, 8 for the second group; sum_valid pulses align with out = 10 then out = 26; grp_count = 2.
- hold:
  - Stimulus: after 2 beats, hold = 1 for 3 cycles with s_valid = 1, then release and send 2 more beats.
  - Response: s_ready = 0 and fill_level = 2 throughout the hold; the group completes with the correct 4 samples.
- flush:
  - Stimulus: beats 9, 9, flush pulse, then beats 1, 2, 3, 4.
  - Response: fill_level returns to 0; the next group is 1, 2, 3, 4; previous in1..in4 stay unchanged until then; s_ready = 0 in the flush cycle.
- Reset mid-operation:
  - Stimulus: assert rst_n = 0 one cycle after grp_strobe.
  - Response: all outputs = 0 immediately; sum_valid never pulses for that group; grp_count = 0.
